// File: rtl/rv_ctl.sv
// ---------------------------------------------------------------------------
// rv_ctl -- multi-cycle RV32I-subset control unit
//
// Purpose:
//   Moore-style FSM (FETCH, DECODE, EXEC, MEM, WB, HALT) that sequences a
//   multi-cycle datapath. Outputs come from the current state, qualified by
//   the decoded instruction, the ALU zero flag and the memory ready strobes.
//   Illegal opcodes send the core to HALT, where it stays until reset.
//
// Ports:
//   clk, rst          clock; asynchronous active-high reset
//   instr[31:0]       instruction register contents
//   zero              ALU result is zero (from this cycle's controls)
//   imem_ready        instruction memory completes this cycle
//   dmem_ready        data memory completes this cycle
//   pcsourse          next-PC select (0 = PC+4, 1 = ALUOUT)
//   pcwrite, pccen    PC write enable, PC-copy (PCC) capture enable
//   irwrite           instruction register load
//   regwen            register file write enable
//   mdrwrite          memory data register load
//   dmem_we           data memory write enable
//   wbsel[1:0]        write-back source (0 = MDR, 1 = ALUOUT, 2 = PC)
//   immsel[1:0]       immediate format (0 = J, 1 = B, 2 = S, 3 = I)
//   asel, bsel        ALU operand selects (A: 0 = reg A, 1 = PCC;
//                     B: 0 = reg B, 1 = IMM)
//   alusel[3:0]       ALU function code
//   halted            illegal instruction seen, core stopped
//   instret[31:0]     retired-instruction counter (only with
//                     RV_CTL_INSTRET_EN defined)
//
// Build option:
//   RV_CTL_INSTRET_EN -- adds the instret output and its counter.
// ---------------------------------------------------------------------------
module rv_ctl (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr,
  input  logic        zero,
  input  logic        imem_ready,
  input  logic        dmem_ready,
  output logic        pcsourse,
  output logic        pcwrite,
  output logic        pccen,
  output logic        irwrite,
  output logic        regwen,
  output logic        mdrwrite,
  output logic        dmem_we,
  output logic [1:0]  wbsel,
  output logic [1:0]  immsel,
  output logic        asel,
  output logic        bsel,
  output logic [3:0]  alusel,
  output logic        halted
`ifdef RV_CTL_INSTRET_EN
  ,
  output logic [31:0] instret
`endif
);

  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_MEM    = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;
  localparam logic [2:0] S_HALT   = 3'd5;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_IALU  = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_SLL  = 4'd2;
  localparam logic [3:0] ALU_SLT  = 4'd3;
  localparam logic [3:0] ALU_SLTU = 4'd4;
  localparam logic [3:0] ALU_XOR  = 4'd5;
  localparam logic [3:0] ALU_SRL  = 4'd6;
  localparam logic [3:0] ALU_SRA  = 4'd7;
  localparam logic [3:0] ALU_OR   = 4'd8;
  localparam logic [3:0] ALU_AND  = 4'd9;

  localparam logic [1:0] IMM_J = 2'd0;
  localparam logic [1:0] IMM_B = 2'd1;
  localparam logic [1:0] IMM_S = 2'd2;
  localparam logic [1:0] IMM_I = 2'd3;

  localparam logic [1:0] WB_MDR = 2'd0;
  localparam logic [1:0] WB_ALU = 2'd1;
  localparam logic [1:0] WB_PC  = 2'd2;

  logic [2:0] r_state;
  logic [2:0] w_next;

  logic [6:0] w_opcode;
  logic [2:0] w_funct3;
  logic       w_isR;
  logic       w_isI;
  logic       w_isLw;
  logic       w_isSw;
  logic       w_isBr;
  logic       w_isJal;
  logic       w_legal;
  logic       w_brTaken;
  logic [3:0] w_aluOp;
  logic       w_unused;

  assign w_opcode = instr[6:0];
  assign w_funct3 = instr[14:12];

  // Only the opcode, funct3 and instr[30] steer control; the register and
  // immediate fields are consumed by the datapath.
  assign w_unused = ^{instr[31], instr[29:15], instr[11:7]};

  assign w_isR   = (w_opcode == OP_R);
  assign w_isI   = (w_opcode == OP_IALU);
  assign w_isLw  = (w_opcode == OP_LOAD)  && (w_funct3 == 3'b010);
  assign w_isSw  = (w_opcode == OP_STORE) && (w_funct3 == 3'b010);
  assign w_isBr  = (w_opcode == OP_BR)    && (w_funct3[2:1] == 2'b00);
  assign w_isJal = (w_opcode == OP_JAL);
  assign w_legal = w_isR | w_isI | w_isLw | w_isSw | w_isBr | w_isJal;

  // funct3[0] separates BNE (taken on non-zero) from BEQ (taken on zero).
  assign w_brTaken = w_funct3[0] ? ~zero : zero;

  // ALU function for R and I-ALU ops; instr[30] only picks SUB for R-type,
  // while it picks SRA for both formats.
  always_comb begin
    w_aluOp = ALU_ADD;
    case (w_funct3)
      3'b000:  w_aluOp = (w_isR && instr[30]) ? ALU_SUB : ALU_ADD;
      3'b001:  w_aluOp = ALU_SLL;
      3'b010:  w_aluOp = ALU_SLT;
      3'b011:  w_aluOp = ALU_SLTU;
      3'b100:  w_aluOp = ALU_XOR;
      3'b101:  w_aluOp = instr[30] ? ALU_SRA : ALU_SRL;
      3'b110:  w_aluOp = ALU_OR;
      default: w_aluOp = ALU_AND;
    endcase
  end

  // State register; reset lands in FETCH so the first fetch happens in the
  // first cycle after release.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_FETCH;
    else     r_state <= w_next;
  end

  // Next state and control outputs. Everything defaults to 0, and while rst
  // is high the outputs stay at their defaults so an aborted instruction
  // cannot write the register file or memory.
  always_comb begin
    w_next   = r_state;
    pcsourse = 1'b0;
    pcwrite  = 1'b0;
    pccen    = 1'b0;
    irwrite  = 1'b0;
    regwen   = 1'b0;
    mdrwrite = 1'b0;
    dmem_we  = 1'b0;
    wbsel    = WB_MDR;
    immsel   = IMM_J;
    asel     = 1'b0;
    bsel     = 1'b0;
    alusel   = ALU_ADD;
    halted   = 1'b0;
    if (!rst) begin
      case (r_state)
        S_FETCH: begin
          if (imem_ready) begin
            irwrite = 1'b1;
            pccen   = 1'b1;
            pcwrite = 1'b1;
            w_next  = S_DECODE;
          end
        end
        S_DECODE: begin
          // Speculatively compute PCC + imm for branch/JAL targets.
          asel   = 1'b1;
          bsel   = 1'b1;
          alusel = ALU_ADD;
          if (w_opcode == OP_BR)       immsel = IMM_B;
          else if (w_opcode == OP_JAL) immsel = IMM_J;
          else                         immsel = IMM_I;
          w_next = w_legal ? S_EXEC : S_HALT;
        end
        S_EXEC: begin
          if (w_isR) begin
            alusel = w_aluOp;
            w_next = S_WB;
          end else if (w_isI) begin
            bsel   = 1'b1;
            immsel = IMM_I;
            alusel = w_aluOp;
            w_next = S_WB;
          end else if (w_isLw || w_isSw) begin
            bsel   = 1'b1;
            immsel = w_isSw ? IMM_S : IMM_I;
            alusel = ALU_ADD;
            w_next = S_MEM;
          end else if (w_isBr) begin
            alusel   = ALU_SUB;
            pcwrite  = w_brTaken;
            pcsourse = w_brTaken;
            w_next   = S_FETCH;
          end else if (w_isJal) begin
            wbsel    = WB_PC;
            regwen   = 1'b1;
            pcwrite  = 1'b1;
            pcsourse = 1'b1;
            w_next   = S_FETCH;
          end else begin
            w_next = S_HALT;
          end
        end
        S_MEM: begin
          // Only LW and SW reach MEM.
          if (dmem_ready) begin
            if (w_isLw) begin
              mdrwrite = 1'b1;
              w_next   = S_WB;
            end else begin
              dmem_we = 1'b1;
              w_next  = S_FETCH;
            end
          end
        end
        S_WB: begin
          regwen = 1'b1;
          wbsel  = w_isLw ? WB_MDR : WB_ALU;
          w_next = S_FETCH;
        end
        S_HALT: begin
          halted = 1'b1;
        end
        default: begin
          w_next = S_FETCH;
        end
      endcase
    end
  end

`ifdef RV_CTL_INSTRET_EN
  logic        w_retire;
  logic [31:0] r_instret;

  // An instruction retires in its last cycle: EXEC for branch/JAL, the
  // completing MEM cycle for SW, and WB for everything else.
  assign w_retire = ((r_state == S_EXEC) && (w_isBr || w_isJal)) ||
                    ((r_state == S_MEM) && w_isSw && dmem_ready) ||
                    (r_state == S_WB);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)           r_instret <= 32'd0;
    else if (w_retire) r_instret <= r_instret + 32'd1;
  end

  assign instret = r_instret;
`endif

endmodule

// File: tb/tb_rv_ctl.sv
// ---------------------------------------------------------------------------
// tb_rv_ctl -- self-checking bench for rv_ctl
//
// A reference model tracks which cycle of the current instruction the core
// is in and derives every control output from the instruction's class.
// Each cycle the bench drives inputs on the falling edge, compares the whole
// output vector against the model, then advances the model on the rising
// edge. A directed prologue pins the model with literal expectations before
// a long randomized run.
// ---------------------------------------------------------------------------
module tb_rv_ctl;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instr;
  logic        zero;
  logic        imem_ready;
  logic        dmem_ready;
  logic        pcsourse, pcwrite, pccen, irwrite, regwen, mdrwrite, dmem_we;
  logic [1:0]  wbsel, immsel;
  logic        asel, bsel;
  logic [3:0]  alusel;
  logic        halted;
`ifdef RV_CTL_INSTRET_EN
  logic [31:0] instret;
`endif

  always #5 clk = ~clk;

  rv_ctl dut (
    .clk        (clk),
    .rst        (rst),
    .instr      (instr),
    .zero       (zero),
    .imem_ready (imem_ready),
    .dmem_ready (dmem_ready),
    .pcsourse   (pcsourse),
    .pcwrite    (pcwrite),
    .pccen      (pccen),
    .irwrite    (irwrite),
    .regwen     (regwen),
    .mdrwrite   (mdrwrite),
    .dmem_we    (dmem_we),
    .wbsel      (wbsel),
    .immsel     (immsel),
    .asel       (asel),
    .bsel       (bsel),
    .alusel     (alusel),
    .halted     (halted)
`ifdef RV_CTL_INSTRET_EN
    ,
    .instret    (instret)
`endif
  );

  localparam logic [31:0] I_ADD = 32'h002081B3;
  localparam logic [31:0] I_BEQ = 32'h00208063;
  localparam logic [31:0] I_BNE = 32'h00209063;
  localparam logic [31:0] I_LW  = 32'h0000A183;
  localparam logic [31:0] I_SW  = 32'h0030A023;
  localparam logic [31:0] I_JAL = 32'h0000006F;
  localparam logic [31:0] I_ILL = 32'h0000007F;

  localparam int K_R = 0, K_I = 1, K_LW = 2, K_SW = 3, K_BR = 4, K_JAL = 5, K_ILL = 6;

  int nCompared   = 0;
  int nMismatched = 0;

  // Model state: cycle index inside the current instruction (0 = fetch),
  // halt flag and retired-instruction count.
  int          mStep    = 0;
  bit          mHalt    = 1'b0;
  logic [31:0] mInstret = 32'd0;

  logic [17:0] dutVec;
  assign dutVec = {pcsourse, pcwrite, pccen, irwrite, regwen, mdrwrite, dmem_we,
                   wbsel, immsel, asel, bsel, alusel, halted};

  function automatic int kindOf(input logic [31:0] ins);
    case (ins[6:0])
      7'b0110011: return K_R;
      7'b0010011: return K_I;
      7'b0000011: return (ins[14:12] == 3'b010) ? K_LW : K_ILL;
      7'b0100011: return (ins[14:12] == 3'b010) ? K_SW : K_ILL;
      7'b1100011: return (ins[14:12] == 3'b000 || ins[14:12] == 3'b001) ? K_BR : K_ILL;
      7'b1101111: return K_JAL;
      default:    return K_ILL;
    endcase
  endfunction

  function automatic logic [3:0] aluFor(input logic [31:0] ins, input bit isReg);
    case (ins[14:12])
      3'b000:  return (isReg && ins[30]) ? 4'd1 : 4'd0;
      3'b001:  return 4'd2;
      3'b010:  return 4'd3;
      3'b011:  return 4'd4;
      3'b100:  return 4'd5;
      3'b101:  return ins[30] ? 4'd7 : 4'd6;
      3'b110:  return 4'd8;
      default: return 4'd9;
    endcase
  endfunction

  function automatic logic [17:0] expectOut(input logic [31:0] ins, input int step,
                                            input bit halt, input logic rstV,
                                            input logic imr, input logic dmr,
                                            input logic z);
    logic pcs, pcw, pcc, irw, rw, mdr, dwe, as, bs, h, take;
    logic [1:0] wb, imm;
    logic [3:0] alu;
    int k;
    pcs = 0; pcw = 0; pcc = 0; irw = 0; rw = 0; mdr = 0; dwe = 0;
    as = 0; bs = 0; h = 0; take = 0; wb = 0; imm = 0; alu = 0;
    k = kindOf(ins);
    if (rstV) begin
    end else if (halt) begin
      h = 1;
    end else begin
      case (step)
        0: if (imr) begin irw = 1; pcc = 1; pcw = 1; end
        1: begin
          as = 1; bs = 1;
          imm = (ins[6:0] == 7'b1100011) ? 2'd1 : (ins[6:0] == 7'b1101111) ? 2'd0 : 2'd3;
        end
        2: begin
          if (k == K_R) alu = aluFor(ins, 1'b1);
          else if (k == K_I) begin bs = 1; imm = 3; alu = aluFor(ins, 1'b0); end
          else if (k == K_LW) begin bs = 1; imm = 3; end
          else if (k == K_SW) begin bs = 1; imm = 2; end
          else if (k == K_BR) begin
            alu = 1;
            take = ins[12] ? !z : z;
            pcw = take; pcs = take;
          end else if (k == K_JAL) begin wb = 2; rw = 1; pcw = 1; pcs = 1; end
        end
        3: begin
          if (k == K_R || k == K_I) begin rw = 1; wb = 1; end
          else if (dmr) begin
            if (k == K_LW) mdr = 1;
            else dwe = 1;
          end
        end
        4: begin rw = 1; wb = 0; end
        default: ;
      endcase
    end
    return {pcs, pcw, pcc, irw, rw, mdr, dwe, wb, imm, as, bs, alu, h};
  endfunction

  function automatic logic [31:0] randInstr();
    logic [31:0] r;
    int c;
    r = $urandom;
    c = $urandom_range(0, 13);
    case (c)
      0, 1, 12, 13: r[6:0] = 7'b0110011;
      2, 3:  r[6:0] = 7'b0010011;
      4:     begin r[6:0] = 7'b0000011; r[14:12] = 3'b010; end
      5:     begin r[6:0] = 7'b0100011; r[14:12] = 3'b010; end
      6:     begin r[6:0] = 7'b1100011; r[14:12] = 3'b000; end
      7:     begin r[6:0] = 7'b1100011; r[14:12] = 3'b001; end
      8:     r[6:0] = 7'b1101111;
      9:     r[6:0] = 7'b1111111;
      10:    begin r[6:0] = 7'b0000011; r[14:12] = 3'b011; end
      default: begin r[6:0] = 7'b1100011; r[14] = 1'b1; end
    endcase
    return r;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatched++;
      $display("[TB] FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  // Drive one cycle's inputs on the falling edge, then compare every output
  // against the model once the combinational outputs have settled.
  task automatic applyStimulus(input logic r, input logic imr, input logic dmr,
                               input logic z, input logic [31:0] ins);
    @(negedge clk);
    rst = r; imem_ready = imr; dmem_ready = dmr; zero = z; instr = ins;
    #1;
    checkOutput("output vector", {14'd0, dutVec},
                {14'd0, expectOut(ins, mStep, mHalt, r, imr, dmr, z)});
`ifdef RV_CTL_INSTRET_EN
    checkOutput("instret", instret, mInstret);
`endif
  endtask

  // Advance the model across the rising edge using the inputs of this cycle.
  task automatic endCycle();
    int k;
    @(posedge clk);
    k = kindOf(instr);
    if (rst) begin
      mStep = 0; mHalt = 0; mInstret = 32'd0;
    end else if (!mHalt) begin
      case (mStep)
        0: if (imem_ready) mStep = 1;
        1: if (k == K_ILL) mHalt = 1; else mStep = 2;
        2: if (k == K_BR || k == K_JAL) begin mStep = 0; mInstret = mInstret + 1; end
           else mStep = 3;
        3: if (k == K_R || k == K_I) begin mStep = 0; mInstret = mInstret + 1; end
           else if (dmem_ready) begin
             if (k == K_SW) begin mStep = 0; mInstret = mInstret + 1; end
             else mStep = 4;
           end
        default: begin mStep = 0; mInstret = mInstret + 1; end
      endcase
    end
  endtask

  logic [31:0] curInstr;
  int          haltCycles;
  logic        rndRst;

  initial begin
    rst = 1'b1; instr = I_ADD; zero = 1'b0; imem_ready = 1'b1; dmem_ready = 1'b1;

    // Reset holds every output low even with imem_ready high.
    applyStimulus(1, 1, 1, 0, I_ADD); checkOutput("reset outputs", {14'd0, dutVec}, 32'd0); endCycle();
    applyStimulus(1, 1, 1, 0, I_ADD); endCycle();

    // ADD x3,x1,x2: next fetch in cycle 5.
    applyStimulus(0, 1, 1, 0, I_ADD); checkOutput("add fetch", {irwrite, pccen, pcwrite, pcsourse}, 4'b1110); endCycle();
    applyStimulus(0, 1, 1, 0, I_ADD); checkOutput("add decode", {asel, bsel, alusel}, 6'b110000); endCycle();
    applyStimulus(0, 1, 1, 0, I_ADD); checkOutput("add exec", {alusel, asel, bsel}, 6'b000000); endCycle();
    applyStimulus(0, 1, 1, 0, I_ADD); checkOutput("add wb", {regwen, wbsel}, 3'b101); endCycle();
    applyStimulus(0, 1, 1, 0, I_BEQ); checkOutput("fetch in cycle 5", irwrite, 1); endCycle();

    // BEQ taken / not taken, BNE taken / not taken.
    applyStimulus(0, 1, 1, 1, I_BEQ); checkOutput("beq decode immsel", immsel, 2'd1); endCycle();
    applyStimulus(0, 1, 1, 1, I_BEQ); checkOutput("beq zero=1", {pcwrite, pcsourse}, 2'b11); endCycle();
    applyStimulus(0, 1, 1, 0, I_BEQ); endCycle();
    applyStimulus(0, 1, 1, 0, I_BEQ); endCycle();
    applyStimulus(0, 1, 1, 0, I_BEQ); checkOutput("beq zero=0", pcwrite, 0); endCycle();
    applyStimulus(0, 1, 1, 0, I_BNE); endCycle();
    applyStimulus(0, 1, 1, 0, I_BNE); endCycle();
    applyStimulus(0, 1, 1, 0, I_BNE); checkOutput("bne zero=0", {pcwrite, pcsourse}, 2'b11); endCycle();
    applyStimulus(0, 1, 1, 1, I_BNE); endCycle();
    applyStimulus(0, 1, 1, 1, I_BNE); endCycle();
    applyStimulus(0, 1, 1, 1, I_BNE); checkOutput("bne zero=1", pcwrite, 0); endCycle();

    // LW with three stalled MEM cycles.
    applyStimulus(0, 1, 1, 0, I_LW); endCycle();
    applyStimulus(0, 1, 1, 0, I_LW); endCycle();
    applyStimulus(0, 1, 1, 0, I_LW); checkOutput("lw exec immsel", immsel, 2'd3); endCycle();
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 1, 0, 0, I_LW); checkOutput("lw stalled mdrwrite", mdrwrite, 0); endCycle();
    end
    applyStimulus(0, 1, 1, 0, I_LW); checkOutput("lw mdrwrite pulse", mdrwrite, 1); endCycle();
    applyStimulus(0, 1, 1, 0, I_LW); checkOutput("lw wb", {regwen, wbsel, mdrwrite}, 4'b1000); endCycle();

    // SW aborted by reset during EXEC, then a complete SW.
    applyStimulus(0, 1, 1, 0, I_SW); endCycle();
    applyStimulus(0, 1, 1, 0, I_SW); endCycle();
    applyStimulus(1, 1, 1, 0, I_SW); checkOutput("sw reset dmem_we", dmem_we, 0); endCycle();
    applyStimulus(0, 1, 1, 0, I_SW); checkOutput("fetch after reset", irwrite, 1); endCycle();
    applyStimulus(0, 1, 1, 0, I_SW); endCycle();
    applyStimulus(0, 1, 1, 0, I_SW); checkOutput("sw exec immsel", immsel, 2'd2); endCycle();
    applyStimulus(0, 1, 1, 0, I_SW); checkOutput("sw mem dmem_we", dmem_we, 1); endCycle();

    // Illegal opcode halts until reset.
    applyStimulus(0, 1, 1, 0, I_ILL); endCycle();
    applyStimulus(0, 1, 1, 0, I_ILL); endCycle();
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 1, 1, 0, I_ILL); checkOutput("halted", {halted, irwrite}, 2'b10); endCycle();
    end
    applyStimulus(1, 1, 1, 0, I_ILL); checkOutput("halt cleared by reset", halted, 0); endCycle();

    // Randomized run against the model.
    curInstr   = I_ADD;
    haltCycles = 0;
    repeat (4000) begin
      if (!mHalt && mStep == 0) curInstr = randInstr();
      if (mHalt) haltCycles++;
      else haltCycles = 0;
      rndRst = (haltCycles > 3) || ($urandom_range(0, 149) == 0);
      applyStimulus(rndRst, $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                    1'($urandom_range(0, 1)), curInstr);
      endCycle();
    end

`ifdef RV_CTL_INSTRET_EN
    // Counter wrap from all-ones to zero on the next retirement.
    applyStimulus(1, 1, 1, 0, I_JAL); endCycle();
    force dut.r_instret = 32'hFFFFFFFF;
    #1;
    release dut.r_instret;
    mInstret = 32'hFFFFFFFF;
    applyStimulus(0, 1, 1, 0, I_JAL); checkOutput("instret preload", instret, 32'hFFFFFFFF); endCycle();
    applyStimulus(0, 1, 1, 0, I_JAL); endCycle();
    applyStimulus(0, 1, 1, 0, I_JAL); endCycle();
    applyStimulus(0, 1, 1, 0, I_JAL); checkOutput("instret wrap", instret, 32'd0); endCycle();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
